// File: rtl/uart_pkg.sv
// Shared constants and types for the ASCII line receiver.
// The serial bit FSM and the line parser both import this package.
package uart_pkg;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_9  = 8'h39;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_t;

  typedef enum logic [1:0] {
    LINE_IDLE,
    LINE_DIGITS,
    LINE_DISCARD
  } line_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, baud down-counter and bit FSM.
// state     | meaning
// BIT_IDLE  | waiting for a falling edge on synced rx
// BIT_START | timing to mid start bit, rejects glitches
// BIT_DATA  | sampling 8 data bits, LSB first
// BIT_STOP  | sampling the stop bit
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW   = $clog2(CPB + 1);
  localparam int HALF = CPB / 2 - 1;
  localparam int FULL = CPB - 1;

  bit_state_t r_state, w_state_nxt;
  logic          r_sync1, r_sync2, r_rx_prev;
  logic [CW-1:0] r_tmr;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_byte_valid, r_frame_err;
  logic          w_tc, w_fall, w_valid_nxt, w_ferr_nxt;

  assign w_tc   = (r_tmr == '0);
  assign w_fall = r_rx_prev & ~r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BIT_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BIT_IDLE:  if (w_fall) w_state_nxt = BIT_START;
      BIT_START: if (w_tc) w_state_nxt = r_sync2 ? BIT_IDLE : BIT_DATA;
      BIT_DATA:  if (w_tc && r_bit_idx == 3'd7) w_state_nxt = BIT_STOP;
      BIT_STOP:  if (w_tc) w_state_nxt = BIT_IDLE;
      default:   w_state_nxt = BIT_IDLE;
    endcase
  end

  always_comb begin
    w_valid_nxt = (r_state == BIT_STOP) && w_tc && r_sync2;
    w_ferr_nxt  = (r_state == BIT_STOP) && w_tc && !r_sync2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        BIT_IDLE: begin
          if (w_fall) begin
            r_tmr     <= CW'(HALF);
            r_bit_idx <= '0;
          end
        end
        BIT_START: r_tmr <= w_tc ? CW'(FULL) : r_tmr - CW'(1);
        BIT_DATA: begin
          if (w_tc) begin
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            r_tmr     <= CW'(FULL);
          end else begin
            r_tmr <= r_tmr - CW'(1);
          end
        end
        BIT_STOP: if (!w_tc) r_tmr <= r_tmr - CW'(1);
        default:  r_tmr <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_valid_nxt;
      r_frame_err  <= w_ferr_nxt;
    end
  end

  assign o_byte_data  = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = (r_state != BIT_IDLE);

endmodule

// File: rtl/uart_ascii_rx.sv
// ASCII decimal line parser: turns CR/LF terminated digit lines into
// 16-bit FIFO writes, with one-cycle error pulses for rejected lines.
// state        | meaning
// LINE_IDLE    | no digits seen since the last terminator
// LINE_DIGITS  | accumulating a valid decimal value
// LINE_DISCARD | line rejected, skipping to the next terminator
module uart_ascii_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int MAX_DIGITS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx,
  input  logic        i_wr_full,
  output logic        o_wr_en,
  output logic [15:0] o_wr_data,
  output logic        o_frame_err,
  output logic        o_fmt_err,
  output logic        o_drop_err,
  output logic        o_busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 2);

  logic [7:0] w_byte_data;
  logic       w_byte_valid, w_frame_err, w_rx_busy;

  uart_rx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_rx_byte (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (i_rx),
    .o_byte_data (w_byte_data),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err),
    .o_busy      (w_rx_busy)
  );

  line_state_t r_state, w_state_nxt;
  logic [16:0]      r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [19:0]      w_acc_mul;
  logic             w_is_digit, w_is_term, w_digit_bad;
  logic             w_wr_en_nxt, w_fmt_nxt, w_drop_nxt;
  logic             r_wr_en, r_fmt_err, r_drop_err, r_frame_err;
  logic [15:0]      r_wr_data;

  assign w_is_digit  = (w_byte_data >= CHAR_0) && (w_byte_data <= CHAR_9);
  assign w_is_term   = (w_byte_data == CHAR_CR) || (w_byte_data == CHAR_LF);
  assign w_acc_mul   = {3'b000, r_acc} * 20'd10 + {16'd0, w_byte_data[3:0]};
  assign w_digit_bad = (w_acc_mul > 20'd65535) || (r_cnt >= CNT_W'(MAX_DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LINE_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A byte with a bad stop bit poisons the current line even before any digit.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    if (w_frame_err) begin
      w_state_nxt = LINE_DISCARD;
    end else if (w_byte_valid) begin
      if (w_is_term) begin
        w_state_nxt = LINE_IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
      end else if (r_state != LINE_DISCARD) begin
        if (w_is_digit && !w_digit_bad) begin
          w_state_nxt = LINE_DIGITS;
          w_acc_nxt   = w_acc_mul[16:0];
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt = LINE_DISCARD;
        end
      end
    end
  end

  always_comb begin
    w_wr_en_nxt = 1'b0;
    w_drop_nxt  = 1'b0;
    w_fmt_nxt   = 1'b0;
    if (w_byte_valid && !w_frame_err) begin
      if (w_is_term) begin
        w_wr_en_nxt = (r_state == LINE_DIGITS) && !i_wr_full;
        w_drop_nxt  = (r_state == LINE_DIGITS) && i_wr_full;
      end else if (r_state != LINE_DISCARD) begin
        w_fmt_nxt = !w_is_digit || w_digit_bad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_fmt_err   <= 1'b0;
      r_drop_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= w_wr_en_nxt;
      r_fmt_err   <= w_fmt_nxt;
      r_drop_err  <= w_drop_nxt;
      r_frame_err <= w_frame_err;
      if (w_wr_en_nxt) r_wr_data <= r_acc[15:0];
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_data   = r_wr_data;
  assign o_fmt_err   = r_fmt_err;
  assign o_drop_err  = r_drop_err;
  assign o_frame_err = r_frame_err;
  // byte_valid bridges the cycle between the bit FSM idling and the line FSM moving
  assign o_busy      = w_rx_busy | w_byte_valid | w_frame_err | (r_state != LINE_IDLE);

endmodule

// File: tb/tb_uart_ascii_rx.sv
// Scoreboard bench for uart_ascii_rx: a string-level line model predicts
// FIFO writes and error pulses; a monitor pops and compares DUT outputs.
module tb_uart_ascii_rx;

  localparam int CLK_FREQ   = 1600000;
  localparam int BAUD       = 100000;
  localparam int MAX_DIGITS = 5;
  localparam int CPB        = CLK_FREQ / BAUD;

  localparam int EV_WR    = 0;
  localparam int EV_FMT   = 1;
  localparam int EV_FRAME = 2;
  localparam int EV_DROP  = 3;

  typedef struct {
    int kind;
    int data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        wr_full = 1'b0;
  logic        wr_en, frame_err, fmt_err, drop_err, busy;
  logic [15:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  ev_t        exp_q[$];
  logic [7:0] m_line[$];
  bit         m_discard = 1'b0;

  uart_ascii_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .MAX_DIGITS(MAX_DIGITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx       (rx),
    .i_wr_full  (wr_full),
    .o_wr_en    (wr_en),
    .o_wr_data  (wr_data),
    .o_frame_err(frame_err),
    .o_fmt_err  (fmt_err),
    .o_drop_err (drop_err),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic bit is_digit(input logic [7:0] c);
    return (c >= 8'd48) && (c <= 8'd57);
  endfunction

  function automatic bit is_term(input logic [7:0] c);
    return (c == 8'd13) || (c == 8'd10);
  endfunction

  function automatic longint line_value();
    longint v = 0;
    foreach (m_line[i]) v = v * 10 + longint'(m_line[i] - 8'd48);
    return v;
  endfunction

  task automatic push_ev(input int kind, input int data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Line-level reference: a line is its digit string; it is judged as bytes arrive.
  task automatic model_byte(input logic [7:0] c, input bit bad_stop);
    if (bad_stop) begin
      push_ev(EV_FRAME, 0);
      m_discard = 1'b1;
    end else if (is_term(c)) begin
      if (!m_discard && m_line.size() > 0) begin
        if (wr_full) push_ev(EV_DROP, 0);
        else         push_ev(EV_WR, int'(line_value()));
      end
      m_line.delete();
      m_discard = 1'b0;
    end else if (!m_discard) begin
      if (!is_digit(c)) begin
        push_ev(EV_FMT, 0);
        m_discard = 1'b1;
      end else begin
        m_line.push_back(c);
        if (m_line.size() > MAX_DIGITS || line_value() > 65535) begin
          push_ev(EV_FMT, 0);
          m_discard = 1'b1;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] c, input bit bad_stop);
    model_byte(c, bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = c[i];
      repeat (CPB) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (bad_stop) repeat (CPB) @(negedge clk);
    repeat ($urandom_range(0, 6)) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic check_ev(input int kind, input int data);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d data=%0d, required no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data) begin
        n_fail++;
        $display("FAIL event_match: got kind=%0d data=%0d, required kind=%0d data=%0d",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en)     check_ev(EV_WR, int'(wr_data));
      if (fmt_err)   check_ev(EV_FMT, 0);
      if (frame_err) check_ev(EV_FRAME, 0);
      if (drop_err)  check_ev(EV_DROP, 0);
    end
  end

  initial begin
    logic [7:0] three;
    logic [7:0] c;
    int         len;
    int         r;

    repeat (5) @(negedge clk);
    check_val("reset_pulses", int'({wr_en, fmt_err, frame_err, drop_err, busy}), 0);
    check_val("reset_wr_data", int'(wr_data), 0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_val("idle_busy", int'(busy), 0);

    send_str("0128\r\n");
    send_str("65535\n");
    send_str("65536\r");
    send_str("12a4\r\n5\r");
    send_str("\r\n\r\n");
    send_str("000128\n");
    send_byte(8'h37, 1'b1);
    send_str("9\n");

    wr_full = 1'b1;
    send_str("42\n");
    wr_full = 1'b0;
    repeat (4) @(negedge clk);

    // Abort "3" during its data bits; the receiver must come back clean.
    three = 8'h33;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = three[i];
      repeat (CPB) @(negedge clk);
    end
    check_val("busy_mid_frame", int'(busy), 1);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_val("mid_reset_outputs", int'({wr_en, fmt_err, frame_err, drop_err, busy}), 0);
    m_line.delete();
    m_discard = 1'b0;
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_val("post_reset_busy", int'(busy), 0);
    send_str("8\n");

    for (int ln = 0; ln < 25; ln++) begin
      wr_full = ($urandom_range(0, 3) == 0);
      len = $urandom_range(0, 7);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 19);
        if (r == 0) begin
          do c = 8'($urandom_range(0, 255)); while (is_digit(c) || is_term(c));
          send_byte(c, 1'b0);
        end else if (r == 1) begin
          send_byte(8'(48 + $urandom_range(0, 9)), 1'b1);
        end else begin
          send_byte(8'(48 + $urandom_range(0, 9)), 1'b0);
        end
      end
      r = $urandom_range(0, 2);
      if (r == 0)      send_str("\r");
      else if (r == 1) send_str("\n");
      else             send_str("\r\n");
    end

    wr_full = 1'b0;
    repeat (100) @(negedge clk);
    check_val("pending_expected_events", exp_q.size(), 0);
    check_val("final_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
